// File: rtl/pulse_to_level_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pulse_to_level_if
// Brief    : Strobe-in / level-out bundle for the pulse_to_level stretcher.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_to_level_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] pulse_in;
    logic [WIDTH-1:0] clear_missed;
    logic [WIDTH-1:0] level_out;
    logic             level_any;
    logic [WIDTH-1:0] missed;

    modport master (
        output pulse_in,
        output clear_missed,
        input  level_out,
        input  level_any,
        input  missed
    );

    modport slave (
        input  pulse_in,
        input  clear_missed,
        output level_out,
        output level_any,
        output missed
    );
endinterface
`default_nettype wire

// File: rtl/pulse_to_level.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pulse_to_level
// Brief    : Per-channel pulse stretcher (HOLD high, optional GAP low guard),
//            sticky missed flag. Option macro: PULSE_TO_LEVEL_RETRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_to_level #(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_to_level_if.slave      bus
);
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    // The IDLE cycle after GAP is itself low, so GAP spans GAP_CYCLES-1 states
    // to give exactly GAP_CYCLES low clocks before the next pulse is accepted.
    localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam bit               C_GAP_EN       = (GAP_CYCLES > 0);
    localparam bit               C_GAP_STATE_EN = (GAP_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_missed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             missed_q, missed_d;
        logic             w_drop;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            w_drop  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.pulse_in[i]) begin
                        state_d = ST_HOLD;
                        cnt_d   = C_HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
                    if (bus.pulse_in[i]) begin
                        cnt_d = C_HOLD_LOAD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - C_CNT_ONE;
                    end else if (C_GAP_STATE_EN) begin
                        state_d = ST_GAP;
                        cnt_d   = C_GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - C_CNT_ONE;
                        w_drop = bus.pulse_in[i];
                    end else if (bus.pulse_in[i] && !C_GAP_EN) begin
                        cnt_d = C_HOLD_LOAD;
                    end else begin
                        w_drop = bus.pulse_in[i];
                        if (C_GAP_STATE_EN) begin
                            state_d = ST_GAP;
                            cnt_d   = C_GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
`endif
                end
                ST_GAP: begin
                    w_drop = bus.pulse_in[i];
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            missed_d = w_drop | (missed_q & ~bus.clear_missed[i]);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                missed_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                missed_q <= missed_d;
            end
        end

        assign w_level[i]  = (state_q == ST_HOLD);
        assign w_missed[i] = missed_q;
    end

    assign bus.level_out = w_level;
    assign bus.missed    = w_missed;
    assign bus.level_any = |w_level;
endmodule
`default_nettype wire
